// File: rtl/return_address_stack.sv
// Call/return stack for the PIC-class core: registered entry array, circular or
// saturating full/empty handling, simultaneous push/pop and sticky error flags.
module return_address_stack #(
  parameter  int WIDTH = 13,
  parameter  int DEPTH = 8,
  parameter  int WRAP  = 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_enable,
  input  logic [WIDTH-1:0] push_value,
  input  logic             pop_enable,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] top_value,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    sp_reg, sp_next;
  logic [PW-1:0]    sp_inc, sp_dec;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             of_set, uf_set;
  logic             is_empty, is_full;
  logic [WIDTH-1:0] mem_rd [DEPTH];

  // Explicit compare-and-wrap keeps non-power-of-two depths correct.
  assign sp_inc   = (sp_reg == LAST_IDX) ? '0 : sp_reg + 1'b1;
  assign sp_dec   = (sp_reg == '0) ? LAST_IDX : sp_reg - 1'b1;
  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == FULL_CNT);

  always_comb begin
    sp_next    = sp_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = sp_reg;
    of_set     = 1'b0;
    uf_set     = 1'b0;
    unique case ({push_enable, pop_enable})
      2'b10: begin
        if (!is_full) begin
          wr_en      = 1'b1;
          sp_next    = sp_inc;
          count_next = count_reg + 1'b1;
        end else begin
          of_set = 1'b1;
          if (WRAP != 0) begin
            wr_en   = 1'b1;
            sp_next = sp_inc;
          end
        end
      end
      2'b01: begin
        if (!is_empty) begin
          sp_next    = sp_dec;
          count_next = count_reg - 1'b1;
        end else begin
          uf_set = 1'b1;
          if (WRAP != 0) sp_next = sp_dec;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Replace-top: the entry being returned through is overwritten in place.
          wr_en  = 1'b1;
          wr_idx = sp_dec;
        end else begin
          uf_set     = 1'b1;
          wr_en      = 1'b1;
          sp_next    = sp_inc;
          count_next = count_reg + 1'b1;
        end
      end
      default: ;
    endcase
    overflow_next  = of_set | (overflow_reg  & ~clear_flags);
    underflow_next = uf_set | (underflow_reg & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_reg        <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_idx == PW'(gi))) begin
          entry_reg <= push_value;
        end
      end
      assign mem_rd[gi] = entry_reg;
    end
  endgenerate

  assign top_value = mem_rd[sp_dec];
  assign count     = count_reg;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
